// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions, transmitter state encoding and helpers.
`timescale 1ns/1ps
package mmio_pkg;

    // Address bits covered by the block's register window (16 bytes).
    localparam int WINDOW_BITS = 4;

    // Register offsets inside the window.
    localparam logic [3:0] TXDATA_OFF = 4'h0;
    localparam logic [3:0] STATUS_OFF = 4'h4;

    // STATUS word bit positions.
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // Transmitter frame states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // FIFO occupancy squeezed into the 4-bit STATUS field, saturating at 15.
    function automatic logic [3:0] sat_count4(input logic [31:0] c);
        logic [3:0] r;
        if (c > 32'd15) begin
            r = 4'd15;
        end else begin
            r = c[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head (no read latency). Pushes
// while full and pops while empty are ignored; pointers wrap naturally.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Bytes written to TXDATA are queued
// and shifted out LSB first; STATUS is returned with RAM-like one-cycle
// read latency so the top level can mux it with block RAM read data.
`timescale 1ns/1ps
module mmio_uart_tx
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
    parameter int          CLK_HZ     = 24000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic [31:0] memory_address,
    input  logic [31:0] memory_write_value,
    input  logic [2:0]  memory_write_sections,
    output logic [31:0] read_value,
    output logic        read_hit,
    output logic        uart_tx
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    // Bus decode: the window is matched on the upper bits, [3:2] pick the register.
    logic        in_win_s;
    logic        txdata_sel_s;
    logic        status_sel_s;
    logic        enq_s;
    logic        clr_s;
    logic        push_s;
    logic        unused_s;

    // FIFO interface.
    logic [7:0]     head_s;
    logic           full_s;
    logic           empty_s;
    logic [FCW-1:0] count_s;
    logic           pop_s;

    // Status and overflow.
    logic        ovf_r;
    logic        busy_s;
    logic [31:0] status_s;

    // Transmitter state.
    tx_state_t        state_r, state_n;
    logic [CNT_W-1:0] cnt_r, cnt_n;
    logic [2:0]       bit_r, bit_n;
    logic [7:0]       shift_r, shift_n;
    logic             tx_r, tx_n;

    assign in_win_s     = (memory_address[31:WINDOW_BITS] == BASE_ADDR[31:WINDOW_BITS]);
    assign txdata_sel_s = in_win_s && (memory_address[3:2] == TXDATA_OFF[3:2]);
    assign status_sel_s = in_win_s && (memory_address[3:2] == STATUS_OFF[3:2]);
    assign enq_s        = txdata_sel_s && memory_write_sections[0];
    assign clr_s        = status_sel_s && memory_write_sections[0];
    // Full is judged before the edge: a write while full is lost even if a pop coincides.
    assign push_s       = enq_s && !full_s;
    assign unused_s     = ^{memory_write_value[31:8], memory_write_sections[2:1],
                            memory_address[1:0]};

    assign busy_s   = (state_r != IDLE) || !empty_s;
    assign status_s = {24'd0, sat_count4(32'(count_s)), ovf_r, busy_s, empty_s, full_s};
    assign uart_tx  = tx_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk24),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (memory_write_value[7:0]),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Sticky overflow flag: set by a dropped TXDATA write, cleared by a STATUS write.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (clr_s) begin
            ovf_r <= 1'b0;
        end else if (enq_s && full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Registered read port: pre-edge status, matching block RAM latency.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            read_hit   <= 1'b0;
            read_value <= 32'd0;
        end else begin
            read_hit   <= in_win_s;
            read_value <= status_sel_s ? status_s : 32'd0;
        end
    end

    // Transmitter state register; the line output is registered here too.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'd0;
            tx_r    <= 1'b1;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            bit_r   <= bit_n;
            shift_r <= shift_n;
            tx_r    <= tx_n;
        end
    end

    // Transmitter next-state logic: start bit, 8 data bits LSB first, stop bit.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        bit_n   = bit_r;
        shift_n = shift_r;
        tx_n    = tx_r;
        pop_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    shift_n = head_s;
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    state_n = START;
                    tx_n    = 1'b0;
                end else begin
                    tx_n = 1'b1;
                end
            end
            START: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_n   = '0;
                    bit_n   = 3'd0;
                    state_n = DATA;
                    tx_n    = shift_r[0];
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_n = '0;
                    if (bit_r == 3'd7) begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end else begin
                        shift_n = {1'b0, shift_r[7:1]};
                        bit_n   = bit_r + 3'd1;
                        tx_n    = shift_r[1];
                    end
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed and randomized bench for mmio_uart_tx. A line monitor decodes
// frames independently from the serial pin; expected bytes and STATUS words
// come from a queue-based model of the transmitter's externally visible rules.
`timescale 1ns/1ps
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 8;
    localparam int          DIV   = 24000000 / 115200;

    logic        clk24;
    logic        rst_n;
    logic [31:0] memory_address;
    logic [31:0] memory_write_value;
    logic [2:0]  memory_write_sections;
    logic [31:0] read_value;
    logic        read_hit;
    logic        uart_tx;

    int tests = 0;
    int fails = 0;
    logic mon_en;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mon_b;

    mmio_uart_tx #(
        .BASE_ADDR  (BASE),
        .CLK_HZ     (24000000),
        .BAUD       (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk24                 (clk24),
        .rst_n                 (rst_n),
        .memory_address        (memory_address),
        .memory_write_value    (memory_write_value),
        .memory_write_sections (memory_write_sections),
        .read_value            (read_value),
        .read_hit              (read_hit),
        .uart_tx               (uart_tx)
    );

    initial clk24 = 1'b0;
    always #5 clk24 = ~clk24;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line monitor: samples each bit near its middle and collects decoded bytes.
    always begin
        @(negedge clk24);
        if (mon_en && rst_n && uart_tx === 1'b0) begin
            repeat (DIV/2 - 1) @(negedge clk24);
            if (mon_en) chk("start_bit", 32'(uart_tx), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk24);
                mon_b[i] = uart_tx;
            end
            repeat (DIV) @(negedge clk24);
            if (mon_en) begin
                chk("stop_bit", 32'(uart_tx), 32'd1);
                rx_q.push_back(mon_b);
            end
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        @(negedge clk24);
        memory_address        = a;
        memory_write_value    = d;
        memory_write_sections = s;
        @(negedge clk24);
        memory_address        = 32'd0;
        memory_write_sections = 3'b000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v, output logic h);
        @(negedge clk24);
        memory_address        = a;
        memory_write_sections = 3'b000;
        @(posedge clk24);
        #1;
        v = read_value;
        h = read_hit;
    endtask

    // Back-to-back TXDATA writes; the model keeps only the bytes the FIFO can take.
    task automatic burst(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            if (n == 10 && i < 10) b = 8'(i);
            if (i < DEPTH + 1) exp_q.push_back(b);
            @(negedge clk24);
            memory_address        = BASE;
            memory_write_value    = {24'hA5A5A5, b};
            memory_write_sections = 3'b001;
        end
        @(negedge clk24);
        memory_address        = 32'd0;
        memory_write_sections = 3'b000;
    endtask

    // Expected STATUS after n back-to-back writes into an idle block (n >= 2):
    // the first byte is already on the line, up to DEPTH more are queued.
    function automatic logic [31:0] burst_status(input int n);
        int acc;
        int q;
        logic [31:0] s;
        acc = (n > DEPTH + 1) ? DEPTH + 1 : n;
        q = acc - 1;
        s = 32'd0;
        s[0] = (q == DEPTH);
        s[2] = 1'b1;
        s[3] = (n > DEPTH + 1);
        s[7:4] = 4'(q);
        return s;
    endfunction

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        logic h;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 25000 && !done; i++) begin
            rd(BASE + 32'd4, v, h);
            if (v == 32'h2) done = 1'b1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic cmp_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            chk({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] v;
        logic h;
        int n;
        int lows;
        bit fell;
        rst_n = 1'b0;
        mon_en = 1'b1;
        memory_address = 32'd0;
        memory_write_value = 32'd0;
        memory_write_sections = 3'b000;
        #12;
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_hit", 32'(read_hit), 32'd0);
        chk("rst_value", read_value, 32'd0);
        @(negedge clk24);
        rst_n = 1'b1;

        rd(BASE + 32'd4, v, h);
        chk("status_hit", 32'(h), 32'd1);
        chk("status_reset", v, 32'h2);

        // Single byte 0x55: latency and start-bit length checked edge by edge.
        exp_q.push_back(8'h55);
        wr(BASE, 32'h0000_0055, 3'b001);
        chk("tx_before_pop", 32'(uart_tx), 32'd1);
        @(posedge clk24); #1;
        chk("tx_start_fall", 32'(uart_tx), 32'd0);
        repeat (DIV - 1) @(posedge clk24);
        #1;
        chk("tx_start_end", 32'(uart_tx), 32'd0);
        @(posedge clk24); #1;
        chk("tx_bit0", 32'(uart_tx), 32'd1);
        rd(BASE + 32'd4, v, h);
        chk("status_busy", v, 32'h6);
        wait_idle("idle_55");
        cmp_rx("rx_55");

        // Ten writes 0..9: nine accepted, last dropped.
        burst(10);
        rd(BASE + 32'd4, v, h);
        chk("status_ovf_8d", v, 32'h8D);
        chk("status_ovf_model", v, burst_status(10));
        wr(BASE + 32'd4, 32'd0, 3'b001);
        rd(BASE + 32'd4, v, h);
        chk("ovf_cleared", 32'(v[3]), 32'd0);
        wait_idle("idle_ovf");
        cmp_rx("rx_ovf");

        // Writes that must not enqueue.
        wr(BASE, 32'h0000_7777, 3'b010);
        wr(BASE, 32'h0077_0000, 3'b100);
        wr(BASE + 32'd8, 32'h0000_0033, 3'b001);
        rd(BASE + 32'd4, v, h);
        chk("no_enqueue", v, 32'h2);
        rd(BASE + 32'd8, v, h);
        chk("rsvd_hit", 32'(h), 32'd1);
        chk("rsvd_value", v, 32'd0);
        rd(BASE, v, h);
        chk("txdata_read", v, 32'd0);
        rd(32'h0000_1000, v, h);
        chk("ram_miss_hit", 32'(h), 32'd0);
        chk("ram_miss_value", v, 32'd0);
        repeat (DIV) @(posedge clk24);
        chk("no_line_activity", 32'(rx_q.size()), 32'd0);

        // Randomized bursts: one within capacity, one overflowing.
        n = $urandom_range(2, 6);
        burst(n);
        rd(BASE + 32'd4, v, h);
        chk("rand_status_a", v, burst_status(n));
        wait_idle("idle_rand_a");
        cmp_rx("rx_rand_a");
        n = $urandom_range(9, 11);
        burst(n);
        rd(BASE + 32'd4, v, h);
        chk("rand_status_b", v, burst_status(n));
        wr(BASE + 32'd4, 32'hFFFF_FFFF, 3'b001);
        wait_idle("idle_rand_b");
        cmp_rx("rx_rand_b");

        // Asynchronous reset mid-frame.
        wr(BASE, 32'h0000_00C3, 3'b001);
        fell = 1'b0;
        for (int i = 0; i < 10 && !fell; i++) begin
            @(posedge clk24); #1;
            if (uart_tx === 1'b0) fell = 1'b1;
        end
        chk("rst_frame_started", 32'(fell), 32'd1);
        memory_address = BASE + 32'd4;
        repeat (999) @(posedge clk24);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(uart_tx), 32'd1);
        chk("async_rst_hit", 32'(read_hit), 32'd0);
        @(negedge clk24);
        rst_n = 1'b1;
        rd(BASE + 32'd4, v, h);
        chk("post_rst_status", v, 32'h2);
        lows = 0;
        repeat (3 * DIV) begin
            @(negedge clk24);
            if (uart_tx !== 1'b1) lows++;
        end
        chk("post_rst_line_idle", 32'(lows), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data bus, downstream of the core alongside block RAM.
- Decodes the core's data-port address/write-lane signals and queues written bytes in a small FIFO.
- Serialises the bytes 8N1, LSB first, on one output pin.
- Returns a registered status word with the same one-cycle read latency as block RAM, so top can mux read data.

Parameters:
- BASE_ADDR, 32'h0001_0000, MMIO base; lies above the 16 KiB RAM window (RAM decodes address[13:2]).
- CLK_HZ, 24000000, frequency of clk24.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD with integer floor, so 208 at the defaults.
- FIFO_DEPTH, 8, entry count; must be a power of 2, ≥2.

Ports:
- clk24  in  1  system clock, the same clock that drives core.
- rst_n  in  1  asynchronous active-low reset.
- memory_address  in  32  core data address.
- memory_write_value  in  32  lane-shifted write data, byte 0 in [7:0] for offset-0 accesses.
- memory_write_sections  in  3  write lanes: [0]=byte0, [1]=byte1, [2]=half[31:16]; 0 means no write.
- read_value  out  32  registered status read data.
- read_hit  out  1  registered: the previous cycle's address was in this block's window.
- uart_tx  out  1  serial line, idle high.

Behaviour:
- Register map, word-aligned:
  - BASE+0 TXDATA, write-only.
  - BASE+4 STATUS, read/write.
  - BASE+8 through BASE+15 are reserved: reads return 0 and writes are ignored.
  - Window is BASE..BASE+15. Decode compares address[31:4]; only address[3:2] select the register.
- Enqueue happens when address==BASE && write_sections[0]. The entry is write_value[7:0], captured at that rising edge.
- Writes with only sections[1] or [2] set do not enqueue.
- Full/overflow rule:
  - Full is judged on the pre-edge count. A write while full is dropped, even if a pop occurs on the same edge.
  - A dropped write sets sticky ovf.
- Any write to BASE+4 with sections[0]=1 clears ovf; the data value is ignored.
- Clear and overflow on the same edge cannot occur, because each is a single-address write.
- STATUS word:
  - bit0 full
  - bit1 empty
  - bit2 busy (FSM not IDLE or FIFO non-empty)
  - bit3 ovf
  - bits[7:4] count, saturating at 15
  - bits[31:8] = 0
- Read timing:
  - Every edge: read_hit <= address in window; read_value <= STATUS if address==BASE+4, else 0.
  - The value reflects pre-edge state, giving a one-cycle latency identical to RAM.
  - Reads have no side effects.
- TX FSM states: IDLE, START, DATA, STOP. Baud counter runs 0..DIV-1; bit index is 0..7.
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, clear the counter, go to START and drive uart_tx=0.
  - START: hold 0 for DIV cycles, then go to DATA with uart_tx = shift[0].
  - DATA: each bit lasts DIV cycles, then shift right. After bit 7, go to STOP with uart_tx=1.
  - STOP: hold 1 for DIV cycles, then go to IDLE. A queued byte starts on the next edge, so there is one extra idle-high cycle between frames.
- Latency: a byte written into an empty idle block is sampled at edge E, popped at E+1, and uart_tx falls after E+1.
- Frame length: 10*DIV cycles plus the 1-cycle IDLE.
- Reset (async, any time including mid-frame):
  - uart_tx=1, read_value=0, read_hit=0.
  - FIFO empty, ovf=0, FSM IDLE, counters 0.
  - A partial frame is abandoned with no resume.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits.

Decomposition:
- Package mmio_pkg holds:
  - Register offsets: TXDATA_OFF=0, STATUS_OFF=4.
  - STATUS bit indices.
  - TX state enum: IDLE/START/DATA/STOP.
  - WINDOW_BITS=4.
- One sub-module, sync_fifo: parameterised WIDTH/DEPTH; push/pop/full/empty/count; async active-low reset; no read latency, head always visible.

Test Plan:
- Reset, then read BASE+4 → next cycle read_hit=1, read_value=32'h0000_0002. uart_tx=1.
- Write 8'h55 to BASE with sections=3'b001 → uart_tx low for 208 cycles, then bits 1,0,1,0,1,0,1,0 at 208 cycles each, then stop high. busy=1 throughout, then STATUS returns to 0x2.
- Ten back-to-back writes of 0x00..0x09 → byte 0 in flight, bytes 1–8 queued, byte 9 dropped. STATUS reads 0x8D (count 8, ovf, busy, full). Line carries 0x00..0x08 only.
- After the overflow case, write 0 to BASE+4 with sections=3'b001 → ovf clears. Then:
  - Write to BASE with sections=3'b010 → no enqueue.
  - Write to BASE+8 → no effect.
  - Read 0x0000_1000 → read_hit=0.
- Assert rst_n low at cycle 1000 of a frame → uart_tx=1 immediately (async). After release, STATUS=0x2 and no further line activity.
